// File: rtl/pclk_gen_pkg.sv
// Shared definitions for the pixel clock divider: run-state encoding and
// the power-on divisor defaults.
package pclk_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pclk_state_e;

    localparam int PCLK_CNT_W        = 16;
    localparam int PCLK_DEFAULT_HALF = 5;

endpackage

// File: rtl/pclk_gen_half_counter.sv
// Half-period counter: counts 0..last and wraps to 0 on terminal count;
// a synchronous clear forces it back to 0.
module half_counter #(
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic             clr,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign tc = (cnt == last);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/pclk_gen.sv
// Programmable pixel clock divider: pclk has a 2N-cycle period with edge strobes,
// a shadowed divisor that only changes at a falling edge, and a phase re-sync.
module pclk_gen
    import pclk_gen_pkg::*;
#(
    parameter int CNT_W        = PCLK_CNT_W,
    parameter int DEFAULT_HALF = PCLK_DEFAULT_HALF
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic             en,
    input  logic [CNT_W-1:0] half_div,
    input  logic             div_load,
    input  logic             sync,
    output logic             pclk,
    output logic             pclk_rise,
    output logic             pclk_fall,
    output logic             div_pending,
    output logic             dbg_state
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pclk_state_e      state, state_nx;
    logic [CNT_W-1:0] div_act, div_act_nx;
    logic [CNT_W-1:0] div_pend_val, div_pend_val_nx;
    logic             div_pending_nx;
    logic             pclk_nx, rise_nx, fall_nx;
    logic [CNT_W-1:0] n_eff, n_last, cnt;
    logic             tc, cnt_clr;
    logic             apply, sync_take, direct;

    // A divisor of 0 would give no phase at all, so it runs as 1.
    assign n_eff  = (div_act == '0) ? ONE : div_act;
    assign n_last = n_eff - ONE;

    half_counter #(.CNT_W(CNT_W)) u_cnt (
        .aclk   (aclk),
        .resetn (resetn),
        .clr    (cnt_clr),
        .last   (n_last),
        .cnt    (cnt),
        .tc     (tc)
    );

    // sync is honoured in IDLE (divisor only) and in RUN while still enabled.
    assign sync_take = sync && ((state == ST_IDLE) || en);
    assign direct    = sync_take && div_load;

    always_comb begin
        state_nx        = state;
        cnt_clr         = 1'b1;
        pclk_nx         = 1'b0;
        rise_nx         = 1'b0;
        fall_nx         = 1'b0;
        apply           = 1'b0;
        div_act_nx      = div_act;
        div_pend_val_nx = div_pend_val;
        div_pending_nx  = div_pending;

        case (state)
            ST_IDLE: begin
                apply = div_pending;
                if (en) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nx = ST_IDLE;
                    fall_nx  = pclk;
                end else if (sync) begin
                    fall_nx = pclk;
                    apply   = div_pending;
                end else begin
                    cnt_clr = 1'b0;
                    if (tc) begin
                        pclk_nx = ~pclk;
                        rise_nx = ~pclk;
                        fall_nx = pclk;
                        // Only a 1->0 toggle may swap divisors, so a high phase is never cut short.
                        apply   = pclk && div_pending;
                    end else begin
                        pclk_nx = pclk;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (direct) begin
            div_act_nx     = half_div;
            div_pending_nx = 1'b0;
        end else begin
            if (apply) begin
                div_act_nx     = div_pend_val;
                div_pending_nx = 1'b0;
            end
            if (div_load) begin
                div_pend_val_nx = half_div;
                div_pending_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            pclk         <= 1'b0;
            pclk_rise    <= 1'b0;
            pclk_fall    <= 1'b0;
            div_act      <= CNT_W'(DEFAULT_HALF);
            div_pend_val <= '0;
            div_pending  <= 1'b0;
        end else begin
            state        <= state_nx;
            pclk         <= pclk_nx;
            pclk_rise    <= rise_nx;
            pclk_fall    <= fall_nx;
            div_act      <= div_act_nx;
            div_pend_val <= div_pend_val_nx;
            div_pending  <= div_pending_nx;
        end
    end

    assign dbg_state = (state == ST_RUN);

endmodule

// File: tb/tb_pclk_gen.sv
// Bench for pclk_gen: directed divisor/sync/enable/reset scenarios plus a random
// soak, all checked every cycle against a deadline-based reference model.
module tb_pclk_gen;
    import pclk_gen_pkg::*;

    localparam int CNT_W = 16;

    logic             aclk = 1'b0;
    logic             resetn = 1'b0;
    logic             en = 1'b0;
    logic [CNT_W-1:0] half_div = '0;
    logic             div_load = 1'b0;
    logic             sync = 1'b0;
    logic             pclk, pclk_rise, pclk_fall, div_pending, dbg_state;

    int n_checks = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: pclk level plus the absolute cycle of its next toggle.
    bit m_run, m_lvl, m_rise, m_fall, m_pend;
    int m_act, m_pend_val, m_next;

    pclk_gen #(.CNT_W(CNT_W), .DEFAULT_HALF(5)) dut (
        .aclk        (aclk),
        .resetn      (resetn),
        .en          (en),
        .half_div    (half_div),
        .div_load    (div_load),
        .sync        (sync),
        .pclk        (pclk),
        .pclk_rise   (pclk_rise),
        .pclk_fall   (pclk_fall),
        .div_pending (div_pending),
        .dbg_state   (dbg_state)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int clamp_n(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic model_reset();
        m_run = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_pend = 0;
        m_act = 5; m_pend_val = 0; m_next = 0;
    endtask

    task automatic model_step();
        bit apply, direct, old_lvl, sched;
        old_lvl = m_lvl; apply = 0; direct = 0; sched = 0;
        if (!m_run) begin
            apply  = m_pend;
            direct = sync && div_load;
            if (en) begin
                m_run = 1; m_lvl = 0; sched = 1;
            end
        end else if (!en) begin
            m_run = 0; m_lvl = 0;
        end else if (sync) begin
            m_lvl = 0; apply = m_pend; direct = div_load; sched = 1;
        end else if (cyc == m_next) begin
            m_lvl = !m_lvl; apply = old_lvl && m_pend; sched = 1;
        end
        if (direct) begin
            m_act = int'(half_div); m_pend = 0;
        end else begin
            if (apply) begin
                m_act = m_pend_val; m_pend = 0;
            end
            if (div_load) begin
                m_pend_val = int'(half_div); m_pend = 1;
            end
        end
        if (sched) m_next = cyc + clamp_n(m_act);
        m_rise = !old_lvl && m_lvl;
        m_fall = old_lvl && !m_lvl;
    endtask

    task automatic step();
        @(posedge aclk);
        cyc++;
        if (!resetn) model_reset();
        else model_step();
        #1;
        check("pclk", pclk, m_lvl);
        check("pclk_rise", pclk_rise, m_rise);
        check("pclk_fall", pclk_fall, m_fall);
        check("div_pending", div_pending, m_pend);
        check("state", dbg_state, m_run);
    endtask

    task automatic pulse_load(input int val);
        half_div = CNT_W'(val);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic wait_for(input bit want_rise, output int n);
        bit seen;
        n = 0; seen = 0;
        while (!seen && n < 200) begin
            step();
            n++;
            seen = want_rise ? pclk_rise : pclk_fall;
        end
        check("strobe_seen", seen, 1);
    endtask

    task automatic async_reset();
        #2 resetn = 1'b0;
        #1;
        check("rst_pclk", pclk, 0);
        check("rst_rise", pclk_rise, 0);
        check("rst_fall", pclk_fall, 0);
        check("rst_pending", div_pending, 0);
        check("rst_state", dbg_state, 0);
        model_reset();
        step();
        step();
        #1 resetn = 1'b1;
    endtask

    initial begin
        int n;
        model_reset();
        step();
        step();
        check("init_pclk", pclk, 0);
        check("init_pending", div_pending, 0);
        check("init_state", dbg_state, 0);
        #1 resetn = 1'b1;
        step();

        // Default divisor: first rise after 5, period 10, half 5.
        en = 1'b1;
        step();
        wait_for(1, n); check("first_rise", n, 5);
        wait_for(1, n); check("period_10", n, 10);
        wait_for(0, n); check("half_5", n, 5);

        // Load 3 during a high phase: the high phase still lasts 5.
        wait_for(1, n);
        step();
        pulse_load(3);
        check("pend_set", div_pending, 1);
        wait_for(0, n); check("high_kept", n, 3);
        check("pend_clr", div_pending, 0);
        wait_for(1, n); check("low_3", n, 3);
        wait_for(1, n); check("period_6", n, 6);

        // Load 0 clamps to 1.
        pulse_load(0);
        wait_for(0, n);
        wait_for(1, n);
        wait_for(1, n); check("period_2", n, 2);

        // sync with pclk high and counter at 2.
        pulse_load(5);
        wait_for(0, n);
        wait_for(1, n); check("rise_n5", n, 5);
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_pclk", pclk, 0);
        check("sync_fall", pclk_fall, 1);
        wait_for(1, n); check("sync_rise", n, 5);

        // Drop enable mid-high, then re-enable.
        step();
        step();
        en = 1'b0;
        step();
        check("drop_pclk", pclk, 0);
        check("drop_fall", pclk_fall, 1);
        step();
        check("idle_fall", pclk_fall, 0);
        check("idle_state", dbg_state, 0);
        en = 1'b1;
        step();
        wait_for(1, n); check("reen_rise", n, 5);

        // Reset with a divisor pending.
        step();
        pulse_load(3);
        check("pend_before_rst", div_pending, 1);
        async_reset();
        step();
        wait_for(1, n); check("post_rst_rise", n, 5);
        wait_for(1, n); check("post_rst_period", n, 10);

        // Random soak.
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 19) != 0);
            div_load = ($urandom_range(0, 9) == 0);
            half_div = CNT_W'($urandom_range(0, 6));
            sync     = ($urandom_range(0, 29) == 0);
            step();
            div_load = 1'b0;
            sync     = 1'b0;
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/pclk_gen.md
PCLK_GEN -- requirements
Module: pclk_gen

Interface
REQ-001 Parameter CNT_W, default 16: width of the half-period counter and divisor ports.
REQ-002 Parameter DEFAULT_HALF, default 5: half-period length in aclk cycles after reset; gives the current aclk/10 pixel clock.
REQ-003 aclk  input  1  the single clock; all logic is rising-edge aclk.
REQ-004 resetn  input  1  asynchronous, active-low reset; assertion acts immediately, and release is sampled on aclk.
REQ-005 en  input  1  run enable; level sensitive.
REQ-006 half_div  input  CNT_W  requested half-period length in aclk cycles.
REQ-007 div_load  input  1  single-cycle pulse; captures half_div into the pending register.
REQ-008 sync  input  1  single-cycle pulse; restarts the pclk phase.
REQ-009 pclk  output  1  divided clock, registered.
REQ-010 pclk_rise  output  1  one-aclk-cycle strobe, high in the first cycle that pclk reads 1.
REQ-011 pclk_fall  output  1  one-aclk-cycle strobe, high in the first cycle that pclk reads 0.
REQ-012 div_pending  output  1  high while a loaded divisor is waiting to be applied.

Function
REQ-013 The block shall use two states: IDLE and RUN.
- IDLE to RUN: when en=1.
- RUN to IDLE: when en=0.
REQ-014 Active half-period N: an effective half_div of 0 shall be clamped to 1.
REQ-015 In RUN, the counter shall increment by 1 each aclk cycle; when counter==N-1, the counter shall go to 0 and pclk shall toggle in the same edge.
REQ-016 Period: the pclk period in RUN shall be exactly 2N aclk cycles, with a 50% duty cycle.
REQ-017 On entering RUN, the counter shall start at 0 and pclk at 0; the first pclk rise shall occur N cycles after the first RUN cycle.
REQ-018 Leaving RUN: on the edge that samples en=0, pclk and the counter shall go to 0.
- pclk_fall shall pulse if pclk was 1.
REQ-019 In IDLE, pclk, the counter and both strobes shall be held at 0.
REQ-020 Strobes:
- pclk_rise and pclk_fall shall be registered alongside pclk, so each coincides with the new pclk value.
- They shall never both be high.
- Each shall last exactly one cycle.
REQ-021 div_load=1 shall capture half_div into the pending register and set div_pending.
- A further load before the pending value is applied shall overwrite it; the last value wins.
REQ-022 Applying the pending divisor:
- In RUN, it shall become active only on the edge where pclk toggles 1 to 0, so no high phase is ever truncated.
- In IDLE, it shall be applied on the next edge.
- div_pending shall clear on the application edge.
REQ-023 div_load and an apply event in the same cycle: the newly captured value shall stay pending, and the older pending value shall be applied.
REQ-024 sync=1 in RUN shall, on that edge, set the counter to 0 and pclk to 0.
- pclk_fall shall pulse if pclk was 1.
- Any pending divisor shall be applied at the same edge.
REQ-025 sync=1 in IDLE shall have no effect other than applying a pending divisor.
REQ-026 sync and div_load in the same cycle: half_div shall be applied directly at that edge, and div_pending shall remain 0.
REQ-027 sync together with counter==N-1: sync shall take priority, so pclk goes to 0 and the counter goes to 0.
REQ-028 Counter arithmetic is unsigned CNT_W bits; the counter shall never exceed N-1 and never wrap.

Reset
REQ-029 While resetn=0, the block shall hold:
- state IDLE;
- pclk=0, pclk_rise=0, pclk_fall=0;
- counter=0;
- active divisor = DEFAULT_HALF;
- pending register = 0, div_pending=0.
REQ-030 Reset asserted mid-period shall discard the partial count and any pending divisor, and the first cycle after release shall behave as fresh IDLE.

Structure
REQ-031 The shared package shall hold the state enum (IDLE, RUN) and the DEFAULT_HALF and CNT_W defaults.
REQ-032 Sub-module half_counter shall hold the counter, the compare against N-1, the clear and the terminal-count output; pclk_gen shall own the state machine, divisor shadow logic and output registers.

Verification
REQ-033 Reset release, en=1, no load: pclk period is 10 aclk cycles, the first rise is 5 cycles after RUN entry, and pclk_rise/pclk_fall alternate every 5 cycles.
REQ-034 Load 3 during a high phase: div_pending=1 until the next 1 to 0 toggle; the high phase completes at 5 cycles, then the period is 6 aclk cycles.
REQ-035 Load 0: N clamps to 1, and pclk toggles every aclk cycle (period 2).
REQ-036 sync asserted with pclk=1 and counter=2: pclk and pclk_fall appear at the next edge, then the first rise comes 5 cycles later.
REQ-037 en dropped mid-high: pclk=0 and pclk_fall=1 for one cycle, then idle; re-enable gives the first rise after N cycles.
REQ-038 resetn pulsed low mid-cycle with a divisor pending: all outputs are 0 immediately, and after release the period is again 10 aclk cycles.
